// File: rtl/spi_burst_ctrl_pkg.sv
// Shared definitions for the SPI burst controller.
// Contents:
//   - default byte width and FIFO depth;
//   - 3-bit FSM state encoding (IDLE, SETUP, ISSUE, WAIT, HOLD);
//   - small integer helper used for counter sizing.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_burst_ctrl_fifo.sv
// spi_sync_fifo: synchronous FIFO with first-word fall-through read port.
// Ports:
//   clk, reset : system clock, synchronous active-high reset (empties FIFO)
//   push, din  : write strobe and data (ignored when full)
//   full       : FIFO holds FIFO_DEPTH entries
//   pop        : read strobe (ignored when empty)
//   dout       : head entry, valid while empty=0
//   empty      : FIFO holds no entries
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int FIFO_DEPTH = SPI_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [ADDR_W:0]       count_r;
    logic                  push_en_s;
    logic                  pop_en_s;

    // Gating on full/empty gives push-only when empty and pop-only when full.
    assign push_en_s = push & ~full;
    assign pop_en_s  = pop & ~empty;

    assign full  = (count_r == (ADDR_W + 1)'(FIFO_DEPTH));
    assign empty = (count_r == {(ADDR_W + 1){1'b0}});
    assign dout  = mem_r[rd_ptr_r];

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W + 1){1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{ADDR_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: sequences a multi-byte SPI burst in front of a byte engine.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : burst command handshake (cmd_len = bytes-1,
//                           cmd_keep_cs leaves ss_n low after the burst)
//   tx_wr, tx_data, tx_full     : host TX FIFO write side
//   rx_rd, rx_data, rx_empty    : host RX FIFO read side (fall-through)
//   busy                  : FSM not idle
//   ss_n                  : slave select, active low, registered
//   spi_start, spi_din    : one-cycle start and byte to the engine
//   spi_ready, spi_done_tick, spi_dout : engine status and received byte
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH   = SPI_DATA_WIDTH,
    parameter int FIFO_DEPTH   = SPI_FIFO_DEPTH,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_len,
    input  logic                  cmd_keep_cs,
    input  logic                  tx_wr,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_full,
    input  logic                  rx_rd,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_empty,
    output logic                  busy,
    output logic                  ss_n,
    output logic                  spi_start,
    output logic [DATA_WIDTH-1:0] spi_din,
    input  logic                  spi_ready,
    input  logic                  spi_done_tick,
    input  logic [DATA_WIDTH-1:0] spi_dout
);

    localparam int CNT_W = $clog2(max_int(CS_SETUP_CYC, CS_HOLD_CYC) + 1);

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [7:0]            rem_r, rem_s;
    logic                  keep_cs_r, keep_cs_s;
    logic                  skip_setup_r, skip_setup_s;
    logic                  ss_n_r, ss_n_s;
    logic                  issue_fire_s;
    logic                  rx_push_s;
    logic                  tx_empty_s;
    logic                  rx_full_s;
    logic [DATA_WIDTH-1:0] tx_head_s;

    spi_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_wr),
        .din   (tx_data),
        .full  (tx_full),
        .pop   (issue_fire_s),
        .dout  (tx_head_s),
        .empty (tx_empty_s)
    );

    spi_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push_s),
        .din   (spi_dout),
        .full  (rx_full_s),
        .pop   (rx_rd),
        .dout  (rx_data),
        .empty (rx_empty)
    );

    // FSM state and burst context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            rem_r        <= 8'd0;
            keep_cs_r    <= 1'b0;
            skip_setup_r <= 1'b0;
            ss_n_r       <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            rem_r        <= rem_s;
            keep_cs_r    <= keep_cs_s;
            skip_setup_r <= skip_setup_s;
            ss_n_r       <= ss_n_s;
        end
    end

    // Next-state, counters, slave select and engine/FIFO strobes.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        rem_s        = rem_r;
        keep_cs_s    = keep_cs_r;
        skip_setup_s = skip_setup_r;
        ss_n_s       = ss_n_r;
        issue_fire_s = 1'b0;
        rx_push_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rem_s        = cmd_len;
                    keep_cs_s    = cmd_keep_cs;
                    cnt_s        = {CNT_W{1'b0}};
                    // ss_n still low from a kept-CS burst: setup time already met.
                    skip_setup_s = ~ss_n_r;
                    ss_n_s       = 1'b0;
                    state_s      = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (skip_setup_r) begin
                    state_s = ST_ISSUE;
                end else if (cnt_r == CNT_W'(CS_SETUP_CYC - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_ISSUE;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
                end
            end
            ST_ISSUE: begin
                // RX space is reserved here so the later done tick can always be stored.
                if (!tx_empty_s && !rx_full_s && spi_ready) begin
                    issue_fire_s = 1'b1;
                    state_s      = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (spi_done_tick) begin
                    rx_push_s = 1'b1;
                    if (rem_r == 8'd0) begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_HOLD;
                    end else begin
                        rem_s   = rem_r - 8'd1;
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_W'(CS_HOLD_CYC - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    ss_n_s  = ~keep_cs_r;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                ss_n_s  = 1'b1;
            end
        endcase
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign ss_n      = ss_n_r;
    assign spi_start = issue_fire_s;
    assign spi_din   = issue_fire_s ? tx_head_s : {DATA_WIDTH{1'b0}};

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
- Transaction sequencer directly upstream of the SPI byte engine.
- Buffers host TX bytes in a FIFO and drives the engine's start/din handshake once per byte.
- Captures each received byte on spi_done_tick into an RX FIFO.
- Owns the slave-select line (setup/hold timing) for a multi-byte burst described by one command.

Parameters:
- DATA_WIDTH, 8, byte width; must match the engine's DATA_WIDTH.
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, 2 or more.
- CS_SETUP_CYC, 2, clk cycles from ss_n falling to first spi_start; 1 or more.
- CS_HOLD_CYC, 2, clk cycles from last spi_done_tick to ss_n rising; 1 or more.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  burst command request
- cmd_ready  out  1  controller idle, command accepted when cmd_valid and cmd_ready both high
- cmd_len  in  8  burst length minus 1 (0 = 1 byte, 255 = 256 bytes)
- cmd_keep_cs  in  1  leave ss_n asserted after the burst
- tx_wr  in  1  push tx_data into the TX FIFO
- tx_data  in  DATA_WIDTH  byte to transmit
- tx_full  out  1  TX FIFO full
- rx_rd  in  1  pop the RX FIFO
- rx_data  out  DATA_WIDTH  RX FIFO head (first-word fall-through); valid when rx_empty=0
- rx_empty  out  1  RX FIFO empty
- busy  out  1  burst in progress (state is not IDLE)
- ss_n  out  1  slave select, active low
- spi_start  out  1  one-cycle start pulse to the engine
- spi_din  out  DATA_WIDTH  byte to the engine; valid in the cycle spi_start is high
- spi_ready  in  1  engine idle
- spi_done_tick  in  1  engine byte complete
- spi_dout  in  DATA_WIDTH  engine received byte; sampled on spi_done_tick

Behaviour:
- Reset values: both FIFOs empty, so tx_full=0 and rx_empty=1; cmd_ready=1, busy=0, ss_n=1, spi_start=0, spi_din=0; byte counter 0.
- Reset mid-burst:
  - Returns to IDLE and raises ss_n on the next edge.
  - Discards the in-flight byte and all FIFO contents.
  - The engine shares the same system reset source, inverted for its resetn.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_len into rem and cmd_keep_cs, clear the counter, go to SETUP. ss_n goes low the next cycle unless it is already low from a kept-CS burst.
  - SETUP: count CS_SETUP_CYC cycles, then go to ISSUE. If ss_n was already low on entry, skip counting and go to ISSUE directly.
  - ISSUE: when TX FIFO not empty, RX FIFO not full and spi_ready=1:
    - pulse spi_start for 1 cycle;
    - drive spi_din from the TX head and pop it in the same cycle;
    - go to WAIT.
    - Otherwise stall in ISSUE, with ss_n held low.
  - WAIT: on spi_done_tick, write spi_dout into the RX FIFO (space is guaranteed by the ISSUE check).
    - If rem==0, go to HOLD.
    - Else decrement rem and go to ISSUE.
  - HOLD: count CS_HOLD_CYC cycles, then go to IDLE. ss_n rises on entry to IDLE if keep_cs=0, otherwise stays low.
- Throughput: minimum 1 cycle in ISSUE between consecutive bytes. Any gap is added in the engine's idle state.
- FIFOs (both):
  - Push when full: ignored.
  - Pop when empty: ignored.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged.
  - Simultaneous push and pop when empty: push only.
  - Simultaneous push and pop when full: pop only.
  - Pointers are ADDR_W=$clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. An ADDR_W+1 occupancy counter derives full and empty.
- The host may refill the TX FIFO during a burst.
- A cmd_valid while busy is not accepted; cmd_ready=0 until IDLE.
- spi_done_tick outside WAIT is ignored.

Decomposition:
- Shared package spi_pkg holds:
  - state encodings for IDLE, SETUP, ISSUE, WAIT, HOLD (3-bit);
  - default DATA_WIDTH and FIFO_DEPTH constants.
- One sub-module, spi_sync_fifo (parameters DATA_WIDTH, FIFO_DEPTH), instantiated twice for TX and RX.

Test Plan:
- Single byte: push 0xA5, cmd_len=0, keep_cs=0, engine model loops MOSI to MISO → ss_n low 1 cycle after accept; spi_start exactly 2 cycles later with spi_din=0xA5; after done tick, rx_data=0xA5; ss_n high 2+1 cycles later; cmd_ready=1.
- 4-byte burst: 0x01..0x04 pre-loaded, cmd_len=3 → exactly 4 spi_start pulses in order; RX FIFO yields 0x01..0x04; ss_n low continuously across all bytes.
- TX underrun: cmd_len=2 with 1 byte loaded, second byte pushed 50 cycles later → controller stalls in ISSUE with ss_n low; completes 3 bytes with no spurious spi_start.
- RX backpressure: FIFO_DEPTH=16, 20-byte burst, rx_rd held low → exactly 16 starts, then stall. Popping 1 entry allows exactly 1 more start. No RX byte lost.
- Keep-CS chaining: burst A with keep_cs=1, then burst B with keep_cs=0 → ss_n never rises between bursts; B's first start occurs with no setup delay; ss_n rises after B's hold.
- Reset mid-burst at byte 2 of 4 → next cycle ss_n=1, busy=0, rx_empty=1, tx_full=0; a new 1-byte command afterwards completes normally.
